data_mem_pipe: RTL and testbench
================================

DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, byte-address width; depth = 2^(ADDR_W-2) 32-bit words.
REQ-002 SHALL have parameter RD_LAT, default 1, read latency in cycles, legal range 1..4.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  in  1  request present.
REQ-006 SHALL have port req_ready  out  1  block accepts request this cycle.
REQ-007 SHALL have port we  in  1  1 = store, 0 = load.
REQ-008 SHALL have port addr  in  ADDR_W  byte address.
REQ-009 SHALL have port mode  in  2  00 word, 01 halfword, 10 byte, 11 illegal.
REQ-010 SHALL have port sext  in  1  load sign-extends when 1, zero-extends when 0.
REQ-011 SHALL have port wdata  in  32  store data; halfword uses [15:0], byte uses [7:0].
REQ-012 SHALL have port rsp_valid  out  1  one-cycle response pulse.
REQ-013 SHALL have port rdata  out  32  load result; 0 for stores and errors.
REQ-014 SHALL have port err  out  1  qualified by rsp_valid; request was illegal or misaligned.

Function
REQ-015 SHALL accept a request on a rising edge where req_valid=1 and req_ready=1; exactly one rsp_valid pulse per accepted request.
REQ-016 SHALL implement FSM IDLE, RD_WAIT, RMW, RESP; req_ready=1 only in IDLE; one request outstanding at a time.
REQ-017 SHALL assert rsp_valid exactly L cycles after the accept edge: load L=RD_LAT, word store L=1, subword store L=2, error L=1.
REQ-018 SHALL return to IDLE in the rsp_valid cycle, so a new request may be accepted on the edge ending that cycle (back-to-back, no bubble).
REQ-019 SHALL use little-endian lanes: byte lane = addr[1:0], halfword lane = addr[1]; word index = addr[ADDR_W-1:2].
REQ-020 SHALL flag err=1 for mode=11, halfword with addr[0]=1, or word with addr[1:0]!=00; such a request SHALL NOT modify memory and SHALL return rdata=0.
REQ-021 SHALL perform word store as a single write in the accept cycle.
REQ-022 SHALL perform subword store as read-modify-write: RMW state reads the word, merges the lane, writes back; untouched lanes unchanged.
REQ-023 SHALL extend loaded byte/halfword to 32 bits per sext; word load ignores sext.
REQ-024 SHALL return, for a load accepted immediately after a store's rsp_valid cycle to the same word, the post-store data.
REQ-025 SHALL hold rdata and err at their last values when rsp_valid=0 (only update in the response cycle).
REQ-026 SHALL ignore req_valid while req_ready=0 (inputs not captured; requester holds them).
REQ-027 SHALL wrap nothing: addresses are confined to ADDR_W bits; no out-of-range case exists.

Reset
REQ-028 SHALL, on a clk edge with RST=1, go to IDLE and clear rsp_valid, rdata, err to 0; req_ready=1 from the following cycle.
REQ-029 SHALL abort any in-flight request on RST (no response; a pending RMW write-back SHALL NOT occur); memory contents SHALL NOT be cleared by RST.
REQ-030 SHALL ignore req_valid in a cycle where RST=1.

Verification
REQ-031 Word store 0x12345678 @0x004, then word load @0x004, RD_LAT=1 -> store rsp 1 cycle after accept, load rsp 1 cycle after accept, rdata=0x12345678, err=0.
REQ-032 Byte store 0xAB @0x005 over word 0x12345678 -> rsp 2 cycles after accept; word load @0x004 = 0x1234AB78; byte load @0x005 sext=1 -> 0xFFFFFFAB, sext=0 -> 0x000000AB.
REQ-033 Halfword load @0x003, word load @0x006, mode=11 -> each rsp 1 cycle later with err=1, rdata=0; memory unchanged.
REQ-034 RD_LAT=3, 20 back-to-back word stores @0,4,..,76 of 0xFFFFFFFF*i then loads in reverse -> each load rsp exactly 3 cycles after accept, data matches, req_ready low during waits.
REQ-035 Halfword store 0xBEEF @0x00A accepted, RST asserted the next cycle -> no rsp_valid, outputs 0, word @0x008 unchanged.
REQ-036 Store @0x010 followed on the edge ending its rsp cycle by load @0x010 -> load returns new data, no idle cycle between requests.

Source files
------------

// File: rtl/data_mem_pipe.sv
// rtl/data_mem_pipe.sv - single-port word memory with byte/halfword/word loads and stores
// One request in flight; subword stores are read-modify-write, loads respond after RD_LAT cycles.
module data_mem_pipe #(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        mode,
  input  logic              sext,
  input  logic [31:0]       wdata,
  output logic              rsp_valid,
  output logic [31:0]       rdata,
  output logic              err
);

  localparam int DEPTH = 1 << (ADDR_W - 2);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_WAIT = 2'd1;
  localparam logic [1:0] S_RMW     = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  localparam logic [1:0] M_WORD = 2'd0;
  localparam logic [1:0] M_HALF = 2'd1;
  localparam logic [1:0] M_BYTE = 2'd2;

  // RD_WAIT holds RD_LAT-3 extra cycles; RESP is always the final cycle before the response edge
  localparam logic [1:0] WAIT_INIT = (RD_LAT > 3) ? 2'(RD_LAT - 3) : 2'd0;

  logic [31:0] mem [DEPTH];

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        mode_q, mode_d;
  logic              sext_q, sext_d;
  logic [15:0]       sdata_q, sdata_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [ADDR_W-3:0] rd_idx;
  logic [31:0]       rd_word;
  logic [31:0]       merged;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic              illegal;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [1:0] m, input logic s);
    logic [31:0] sh;
    sh = w >> {lane, 3'b000};
    case (m)
      M_HALF:  load_ext = s ? {{16{sh[15]}}, sh[15:0]} : {16'h0000, sh[15:0]};
      M_BYTE:  load_ext = s ? {{24{sh[7]}}, sh[7:0]} : {24'h000000, sh[7:0]};
      default: load_ext = sh;
    endcase
  endfunction

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rdata     = rdata_q;
  assign err       = err_q;

  assign rd_idx  = (state_q == S_IDLE) ? addr[ADDR_W-1:2] : addr_q[ADDR_W-1:2];
  assign rd_word = mem[rd_idx];
  assign illegal = (mode == 2'b11) || ((mode == M_HALF) && addr[0]) ||
                   ((mode == M_WORD) && (addr[1:0] != 2'b00));

  always_comb begin
    merged = rd_word;
    if (mode_q == M_HALF) merged[{addr_q[1], 4'b0000} +: 16] = sdata_q;
    else                  merged[{addr_q[1:0], 3'b000} +: 8] = sdata_q[7:0];
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    mode_d      = mode_q;
    sext_d      = sext_q;
    sdata_d     = sdata_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mem_we      = 1'b0;
    mem_wdata   = merged;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = addr;
          mode_d  = mode;
          sext_d  = sext;
          sdata_d = wdata[15:0];
          if (illegal) begin
            rsp_valid_d = 1'b1;
            rdata_d     = 32'h0;
            err_d       = 1'b1;
          end else if (we && (mode == M_WORD)) begin
            mem_we      = 1'b1;
            mem_wdata   = wdata;
            rsp_valid_d = 1'b1;
            rdata_d     = 32'h0;
            err_d       = 1'b0;
          end else if (we) begin
            state_d = S_RMW;
          end else if (RD_LAT <= 1) begin
            rsp_valid_d = 1'b1;
            rdata_d     = load_ext(rd_word, addr[1:0], mode, sext);
            err_d       = 1'b0;
          end else if (RD_LAT == 2) begin
            state_d = S_RESP;
          end else begin
            state_d = S_RD_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == 2'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 2'd1;
      end
      S_RESP: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        rdata_d     = load_ext(rd_word, addr_q[1:0], mode_q, sext_q);
        err_d       = 1'b0;
      end
      S_RMW: begin
        state_d     = S_IDLE;
        mem_we      = 1'b1;
        rsp_valid_d = 1'b1;
        rdata_d     = 32'h0;
        err_d       = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      mode_q      <= 2'b00;
      sext_q      <= 1'b0;
      sdata_q     <= 16'h0;
      cnt_q       <= 2'd0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      mode_q      <= mode_d;
      sext_q      <= sext_d;
      sdata_q     <= sdata_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Memory survives reset; a reset edge also cancels a pending RMW write-back
  always_ff @(posedge clk) begin
    if (!RST && mem_we) mem[rd_idx] <= mem_wdata;
  end

endmodule

// File: tb/tb_data_mem_pipe.sv
// tb/tb_data_mem_pipe.sv - self-checking bench for data_mem_pipe (RD_LAT=1 and RD_LAT=3 instances)
module tb_data_mem_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [11:0] addr = 12'h0;
  logic [1:0]  mode = 2'b00;
  logic        sext = 1'b0;
  logic [31:0] wdata = 32'h0;

  logic        req_valid1 = 1'b0, req_ready1, rsp_valid1, err1;
  logic [31:0] rdata1;
  logic        req_valid3 = 1'b0, req_ready3, rsp_valid3, err3;
  logic [31:0] rdata3;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_pipe #(.ADDR_W(12), .RD_LAT(1)) dut1 (
    .clk(clk), .RST(rst), .req_valid(req_valid1), .req_ready(req_ready1), .we(we),
    .addr(addr), .mode(mode), .sext(sext), .wdata(wdata), .rsp_valid(rsp_valid1),
    .rdata(rdata1), .err(err1));

  data_mem_pipe #(.ADDR_W(12), .RD_LAT(3)) dut3 (
    .clk(clk), .RST(rst), .req_valid(req_valid3), .req_ready(req_ready3), .we(we),
    .addr(addr), .mode(mode), .sext(sext), .wdata(wdata), .rsp_valid(rsp_valid3),
    .rdata(rdata3), .err(err3));

  typedef struct {
    int          sel;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [1:0]  mode;
    logic        sext;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic take_rsp(input int sel, input logic [31:0] rd, input logic e);
    exp_t x;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_rsp dut%0d: got rdata 0x%08h err %0d, expected no response", sel, rd, e);
    end else begin
      x = sb.pop_front();
      check("rsp_dut", sel, x.sel);
      check("rsp_rdata", rd, x.rdata);
      check("rsp_err", 32'(e), 32'(x.err));
      check("rsp_latency", cyc - x.acc + 1, x.lat);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid1) take_rsp(1, rdata1, err1);
    if (rsp_valid3) take_rsp(3, rdata3, err3);
  end

  task automatic issue(input int sel, input logic w, input logic [11:0] a, input logic [1:0] m,
                       input logic s, input logic [31:0] wd, input logic [31:0] er,
                       input logic ee, input int el, input int exp_busy);
    int   busy;
    bit   ok;
    exp_t x;
    we = w; addr = a; mode = m; sext = s; wdata = wd;
    if (sel == 1) req_valid1 = 1'b1;
    else          req_valid3 = 1'b1;
    busy = 0;
    ok   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((sel == 1) ? req_ready1 : req_ready3) begin
        ok = 1'b1;
        break;
      end
      busy++;
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout dut%0d addr 0x%03h: got req_ready=0 for 20 cycles, expected 1", sel, a);
      req_valid1 = 1'b0;
      req_valid3 = 1'b0;
      return;
    end
    if (exp_busy >= 0) check("busy_cycles", busy, exp_busy);
    @(posedge clk);
    #1;
    req_valid1 = 1'b0;
    req_valid3 = 1'b0;
    x = '{sel, er, ee, el, cyc};
    sb.push_back(x);
  endtask

  task automatic add(input logic w, input logic [11:0] a, input logic [1:0] m, input logic s,
                     input logic [31:0] wd, input logic [31:0] er, input logic ee, input int el);
    vec_t v;
    v = '{w, a, m, s, wd, er, ee, el};
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          prev_lat;
    logic [31:0] d;

    //   we    addr     mode  sext wdata          rdata          err  lat
    add(1'b1, 12'h004, 2'd0, 1'b0, 32'h12345678, 32'h00000000, 1'b0, 1);
    add(1'b0, 12'h004, 2'd0, 1'b0, 32'h0,        32'h12345678, 1'b0, 1);
    add(1'b1, 12'h005, 2'd2, 1'b0, 32'hCDEF01AB, 32'h00000000, 1'b0, 2);
    add(1'b0, 12'h004, 2'd0, 1'b1, 32'h0,        32'h1234AB78, 1'b0, 1);
    add(1'b0, 12'h005, 2'd2, 1'b1, 32'h0,        32'hFFFFFFAB, 1'b0, 1);
    add(1'b0, 12'h005, 2'd2, 1'b0, 32'h0,        32'h000000AB, 1'b0, 1);
    add(1'b0, 12'h003, 2'd1, 1'b0, 32'h0,        32'h00000000, 1'b1, 1);
    add(1'b0, 12'h006, 2'd0, 1'b0, 32'h0,        32'h00000000, 1'b1, 1);
    add(1'b0, 12'h004, 2'd3, 1'b0, 32'h0,        32'h00000000, 1'b1, 1);
    add(1'b1, 12'h004, 2'd3, 1'b0, 32'hDEADBEEF, 32'h00000000, 1'b1, 1);
    add(1'b1, 12'h006, 2'd0, 1'b0, 32'hDEADBEEF, 32'h00000000, 1'b1, 1);
    add(1'b1, 12'h005, 2'd1, 1'b0, 32'hDEADBEEF, 32'h00000000, 1'b1, 1);
    add(1'b0, 12'h004, 2'd0, 1'b0, 32'h0,        32'h1234AB78, 1'b0, 1);
    add(1'b1, 12'h006, 2'd1, 1'b0, 32'h55558001, 32'h00000000, 1'b0, 2);
    add(1'b0, 12'h006, 2'd1, 1'b1, 32'h0,        32'hFFFF8001, 1'b0, 1);
    add(1'b0, 12'h006, 2'd1, 1'b0, 32'h0,        32'h00008001, 1'b0, 1);
    add(1'b0, 12'h004, 2'd0, 1'b0, 32'h0,        32'h8001AB78, 1'b0, 1);
    add(1'b1, 12'h007, 2'd2, 1'b0, 32'h1234567F, 32'h00000000, 1'b0, 2);
    add(1'b0, 12'h007, 2'd2, 1'b1, 32'h0,        32'h0000007F, 1'b0, 1);
    add(1'b0, 12'h004, 2'd1, 1'b1, 32'h0,        32'hFFFFAB78, 1'b0, 1);
    add(1'b0, 12'h004, 2'd2, 1'b1, 32'h0,        32'h00000078, 1'b0, 1);
    add(1'b0, 12'h004, 2'd0, 1'b0, 32'h0,        32'h7F01AB78, 1'b0, 1);
    add(1'b1, 12'h010, 2'd0, 1'b0, 32'hCAFEF00D, 32'h00000000, 1'b0, 1);
    add(1'b0, 12'h010, 2'd0, 1'b0, 32'h0,        32'hCAFEF00D, 1'b0, 1);
    add(1'b1, 12'h010, 2'd2, 1'b0, 32'h00000099, 32'h00000000, 1'b0, 2);
    add(1'b0, 12'h010, 2'd0, 1'b0, 32'h0,        32'hCAFEF099, 1'b0, 1);
    add(1'b1, 12'h008, 2'd0, 1'b0, 32'h11223344, 32'h00000000, 1'b0, 1);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_rsp_valid1", 32'(rsp_valid1), 32'h0);
    check("reset_rdata1", rdata1, 32'h0);
    check("reset_err1", 32'(err1), 32'h0);
    check("reset_ready1", 32'(req_ready1), 32'h1);
    check("reset_rsp_valid3", 32'(rsp_valid3), 32'h0);
    check("reset_rdata3", rdata3, 32'h0);
    check("reset_err3", 32'(err3), 32'h0);
    check("reset_ready3", 32'(req_ready3), 32'h1);
    @(posedge clk);
    #1;

    // Back-to-back table run: each request waits exactly (previous latency - 1) not-ready cycles
    prev_lat = 1;
    for (int i = 0; i < tbl.size(); i++) begin
      issue(1, tbl[i].we, tbl[i].addr, tbl[i].mode, tbl[i].sext, tbl[i].wdata,
            tbl[i].exp_rdata, tbl[i].exp_err, tbl[i].exp_lat, prev_lat - 1);
      prev_lat = tbl[i].exp_lat;
    end

    // Halfword store aborted by reset during its RMW cycle
    we = 1'b1; addr = 12'h00A; mode = 2'd1; sext = 1'b0; wdata = 32'h0000BEEF;
    req_valid1 = 1'b1;
    @(negedge clk);
    check("abort_accept_ready", 32'(req_ready1), 32'h1);
    @(posedge clk);
    #1 req_valid1 = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_rsp_valid", 32'(rsp_valid1), 32'h0);
    check("abort_rdata", rdata1, 32'h0);
    check("abort_err", 32'(err1), 32'h0);
    check("abort_ready", 32'(req_ready1), 32'h1);
    @(posedge clk);
    #1;
    issue(1, 1'b0, 12'h008, 2'd0, 1'b0, 32'h0, 32'h11223344, 1'b0, 1, 0);
    issue(1, 1'b0, 12'h00A, 2'd1, 1'b0, 32'h0, 32'h00001122, 1'b0, 1, 0);

    // Outputs hold between responses
    repeat (3) @(negedge clk);
    check("hold_rsp_valid", 32'(rsp_valid1), 32'h0);
    check("hold_rdata", rdata1, 32'h00001122);
    check("hold_err", 32'(err1), 32'h0);
    @(posedge clk);
    #1;

    // RD_LAT=3: 20 word stores, then loads in reverse order
    for (int i = 0; i < 20; i++) begin
      d = 32'hFFFFFFFF * i;
      issue(3, 1'b1, 12'(4 * i), 2'd0, 1'b0, d, 32'h0, 1'b0, 1, 0);
    end
    for (int i = 19; i >= 0; i--) begin
      d = 32'hFFFFFFFF * i;
      issue(3, 1'b0, 12'(4 * i), 2'd0, 1'b0, 32'h0, d, 1'b0, 3, (i == 19) ? 0 : 2);
    end

    repeat (8) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
